tremolo_mod: RTL and testbench

Parametrised multi-channel tremolo for the audio effect chain. It amplitude-modulates each channel with an internal low-frequency oscillator (LFO), and supports selectable waveform, depth, rate and stereo auto-pan. It sits in the sample-valid effect chain between adjacent effect stages and has fixed latency whether enabled or bypassed.

---
 rtl/tremolo_pkg.sv | 42 ++++
 rtl/tremolo_mod_lfo_gen.sv | 55 +++++
 rtl/tremolo_mod.sv | 108 ++++++++++
 tb/tb_tremolo_mod.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tremolo_pkg.sv
// Shared types, constants and helpers for the tremolo effect.
// Optional feature macro: TREMOLO_SMOOTH_EN (gain slew limiter).
package tremolo_pkg;

  typedef enum logic [1:0] {
    TRI     = 2'd0,
    SQR     = 2'd1,
    RAMP_UP = 2'd2,
    RAMP_DN = 2'd3
  } lfo_mode_e;

  // Phase increments per accepted sample, tuned for 48 kHz and a 24-bit
  // accumulator: 0.5, 1, 2, 3, 4, 6, 8 and 12 Hz.
  localparam logic [23:0] INC [8] = '{
    24'd175, 24'd350, 24'd699, 24'd1049,
    24'd1398, 24'd2097, 24'd2796, 24'd4194
  };

  localparam logic [16:0] SLEW_STEP  = 17'd512;
  localparam logic [16:0] UNITY_GAIN = 17'd32768;

  // Q1.15 gain for a given depth and LFO level; full LFO gives unity.
  function automatic logic [16:0] gainFromLfo(input logic [7:0] depth,
                                              input logic [14:0] lfo);
    logic [22:0] prod;
    prod = 23'(depth) * 23'(15'h7FFF - lfo);
    return UNITY_GAIN - {2'b00, prod[22:8]};
  endfunction

  // Moves cur toward target by no more than SLEW_STEP.
  function automatic logic [16:0] slewToward(input logic [16:0] cur,
                                             input logic [16:0] target);
    if (target > cur + SLEW_STEP) begin
      return cur + SLEW_STEP;
    end else if (target + SLEW_STEP < cur) begin
      return cur - SLEW_STEP;
    end else begin
      return target;
    end
  endfunction

endpackage

// File: rtl/tremolo_mod_lfo_gen.sv
// Low-frequency oscillator for the tremolo: phase accumulator plus
// waveform shaping. The level output reflects the current (registered)
// phase, so a sample strobed this cycle uses the phase before its step.
module lfo_gen #(
  parameter int PHASE_W = 24
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_enable,
  input  logic [1:0]  i_mode,
  input  logic [2:0]  i_freq,
  output logic [14:0] o_lfo
);
  import tremolo_pkg::*;

  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;
  logic [15:0]        p;
  lfo_mode_e          mode;

  // Advance on each accepted sample; hold at zero while bypassed so the
  // oscillator restarts cleanly when the effect is re-enabled.
  always_comb begin
    phase_d = phase_q;
    if (!i_enable) begin
      phase_d = '0;
    end else if (i_valid) begin
      phase_d = phase_q + PHASE_W'(INC[i_freq]);
    end
  end

  // Phase register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Shape the top 16 phase bits into a 15-bit unsigned level.
  always_comb begin
    p    = phase_q[PHASE_W-1 -: 16];
    mode = lfo_mode_e'(i_mode);
    case (mode)
      TRI:     o_lfo = p[15] ? ~p[14:0] : p[14:0];
      SQR:     o_lfo = p[15] ? 15'd0 : 15'h7FFF;
      RAMP_UP: o_lfo = p[15:1];
      RAMP_DN: o_lfo = ~p[15:1];
      default: o_lfo = 15'd0;
    endcase
  end

endmodule

// File: rtl/tremolo_mod.sv
// Multi-channel tremolo: amplitude-modulates each channel with a shared
// LFO, optional auto-pan on odd channels, fixed two-cycle latency.
// Optional feature macro: TREMOLO_SMOOTH_EN (gain slew limiter).
module tremolo_mod #(
  parameter int DATA_W  = 16,
  parameter int CH      = 2,
  parameter int PHASE_W = 24
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic                 i_enable,
  input  logic [1:0]           i_mode,
  input  logic [2:0]           i_freq,
  input  logic [7:0]           i_depth,
  input  logic                 i_pan,
  input  logic [CH*DATA_W-1:0] i_data,
  output logic [CH*DATA_W-1:0] o_data,
  output logic                 o_valid
);
  import tremolo_pkg::*;

  logic [14:0]       lfo;
  logic              valid1_q;
  logic              valid2_q;
  logic [DATA_W-1:0] data1_q [CH];
  logic [16:0]       gain1_q [CH];
  logic [DATA_W-1:0] out_q   [CH];

  lfo_gen #(
    .PHASE_W (PHASE_W)
  ) u_lfo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .i_enable (i_enable),
    .i_mode   (i_mode),
    .i_freq   (i_freq),
    .o_lfo    (lfo)
  );

  // Strobe pipeline: every input strobe emerges exactly two cycles later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
    end else begin
      valid1_q <= i_valid;
      valid2_q <= valid1_q;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [14:0]              chLfo;
    logic [16:0]              target;
    logic [16:0]              gain_d;
    logic signed [DATA_W+17:0] prod;
    logic [DATA_W-1:0]        y;

    // Per-channel target gain; odd channels follow the inverted LFO when panning.
    always_comb begin
      chLfo  = (i_pan && (c % 2 == 1)) ? ~lfo : lfo;
      target = i_enable ? gainFromLfo(i_depth, chLfo) : UNITY_GAIN;
`ifdef TREMOLO_SMOOTH_EN
      gain_d = i_valid ? slewToward(gain1_q[c], target) : gain1_q[c];
`else
      gain_d = i_valid ? target : gain1_q[c];
`endif
    end

    // Stage 1: capture the sample and the gain it will be scaled by.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        data1_q[c] <= '0;
`ifdef TREMOLO_SMOOTH_EN
        gain1_q[c] <= UNITY_GAIN;
`else
        gain1_q[c] <= '0;
`endif
      end else begin
        gain1_q[c] <= gain_d;
        if (i_valid) begin
          data1_q[c] <= i_data[c*DATA_W +: DATA_W];
        end
      end
    end

    // Gain never exceeds unity, so the floored product always fits DATA_W.
    always_comb begin
      prod = $signed(data1_q[c]) * $signed({1'b0, gain1_q[c]});
      y    = DATA_W'(prod >>> 15);
    end

    // Stage 2: register the scaled sample.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        out_q[c] <= '0;
      end else if (valid1_q) begin
        out_q[c] <= y;
      end
    end

    assign o_data[c*DATA_W +: DATA_W] = out_q[c];
  end

  assign o_valid = valid2_q;

endmodule

// File: tb/tb_tremolo_mod.sv
// Directed testbench for tremolo_mod (two 16-bit channels, 24-bit phase).
// Expectations follow the default build; with TREMOLO_SMOOTH_EN defined the
// square test checks the slewed edge and gain-stepping tests are skipped.
module tb_tremolo_mod;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        i_enable;
  logic [1:0]  i_mode;
  logic [2:0]  i_freq;
  logic [7:0]  i_depth;
  logic        i_pan;
  logic [31:0] i_data;
  logic [31:0] o_data;
  logic        o_valid;

  int checks = 0;
  int passes = 0;

  always #5 i_clk = ~i_clk;

  tremolo_mod #(
    .DATA_W  (16),
    .CH      (2),
    .PHASE_W (24)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .i_enable (i_enable),
    .i_mode   (i_mode),
    .i_freq   (i_freq),
    .i_depth  (i_depth),
    .i_pan    (i_pan),
    .i_data   (i_data),
    .o_data   (o_data),
    .o_valid  (o_valid)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic setCtrl(input logic en, input logic [1:0] mode,
                         input logic [2:0] freq, input logic [7:0] depth,
                         input logic pan);
    i_enable = en;
    i_mode   = mode;
    i_freq   = freq;
    i_depth  = depth;
    i_pan    = pan;
  endtask

  // Bypass for a cycle to zero the phase, then let the pipeline drain.
  task automatic clearPhase();
    i_valid  = 1'b0;
    i_enable = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_valid = 1'b1;
    setCtrl(1'b0, 2'd0, 3'd0, 8'd0, 1'b0);
    i_data = 32'h1111_2222;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (o_valid !== 1'b0 || o_data !== 32'h0)
        $display("[TB] FAIL reset_hold: o_valid=%b o_data=%h, want 0/00000000", o_valid, o_data);
      else passes++;
    end
    i_valid = 1'b0;
    i_rst_n = 1'b1;
    step();
    step();
    checks++;
    if (o_valid !== 1'b0)
      $display("[TB] FAIL reset_idle: o_valid=%b, want 0", o_valid);
    else passes++;
    i_valid = 1'b1;
    i_data  = 32'hABCD_0042;
    step();
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b0)
      $display("[TB] FAIL reset_latency1: o_valid=%b, want 0", o_valid);
    else passes++;
    step();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 32'hABCD_0042)
      $display("[TB] FAIL reset_first: o_valid=%b o_data=%h, want 1/abcd0042", o_valid, o_data);
    else passes++;
  endtask

  task automatic test_reset_mid();
    i_valid = 1'b1;
    i_data  = 32'h5555_6666;
    step();
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_data !== 32'h0)
      $display("[TB] FAIL reset_mid: o_valid=%b o_data=%h, want 0/00000000", o_valid, o_data);
    else passes++;
    step();
    i_rst_n = 1'b1;
    step();
    step();
    checks++;
    if (o_valid !== 1'b0 || o_data !== 32'h0)
      $display("[TB] FAIL reset_mid_flush: o_valid=%b o_data=%h, want 0/00000000", o_valid, o_data);
    else passes++;
  endtask

  task automatic test_bypass();
    clearPhase();
    setCtrl(1'b0, 2'd1, 3'd7, 8'd255, 1'b1);
    i_data  = {16'hFFFB, 16'h1234};
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    step();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 32'hFFFB_1234)
      $display("[TB] FAIL bypass: o_valid=%b o_data=%h, want 1/fffb1234", o_valid, o_data);
    else passes++;
    checks++;
    if (dut.u_lfo.phase_q !== 24'd0)
      $display("[TB] FAIL bypass_phase: phase=%0d, want 0", dut.u_lfo.phase_q);
    else passes++;
  endtask

  task automatic test_depth_zero();
    logic [31:0] vec [3];
    vec[0] = 32'h7FFF_8000;
    vec[1] = 32'h0001_FFFF;
    vec[2] = 32'h5A5A_A5A5;
    for (int m = 0; m < 4; m++) begin
      for (int v = 0; v < 3; v++) begin
        setCtrl(1'b1, 2'(m), 3'd7, 8'd0, 1'b1);
        i_data  = vec[v];
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        step();
        checks++;
        if (o_valid !== 1'b1 || o_data !== vec[v])
          $display("[TB] FAIL depth_zero mode%0d vec%0d: o_data=%h, want %h", m, v, o_data, vec[v]);
        else passes++;
      end
    end
  endtask

  task automatic test_square_max();
    localparam int N = 2012;
    logic [15:0] exp;
    clearPhase();
    setCtrl(1'b1, 2'd1, 3'd7, 8'd255, 1'b0);
    i_data = 32'h4000_4000;
    for (int n = 0; n <= N; n++) begin
      i_valid = (n < N);
      step();
      if (n >= 1) begin
`ifdef TREMOLO_SMOOTH_EN
        exp = (n - 1 <= 2000) ? 16'd16384 : 16'(16384 - 256 * (n - 1 - 2000));
`else
        exp = (n - 1 <= 2000) ? 16'd16384 : 16'd64;
`endif
        checks++;
        if (o_valid !== 1'b1 || o_data !== {exp, exp})
          $display("[TB] FAIL square sample%0d: o_valid=%b o_data=%h, want 1/%h%h", n - 1, o_valid, o_data, exp, exp);
        else passes++;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic test_autopan();
    clearPhase();
    setCtrl(1'b1, 2'd0, 3'd0, 8'd128, 1'b1);
    i_data  = 32'h7FFF_7FFF;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    step();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 32'h7FFF_4000)
      $display("[TB] FAIL autopan: o_data=%h, want 7fff4000", o_data);
    else passes++;
  endtask

  // Two samples per waveform from phase 0 at 12 Hz, depth 255, x = 16384.
  task automatic test_waveforms();
    logic [1:0]  modes [3];
    logic [15:0] exp0  [3];
    logic [15:0] exp1  [3];
    modes[0] = 2'd0; exp0[0] = 16'd64;    exp1[0] = 16'd72;
    modes[1] = 2'd2; exp0[1] = 16'd64;    exp1[1] = 16'd68;
    modes[2] = 2'd3; exp0[2] = 16'd16384; exp1[2] = 16'd16380;
    for (int w = 0; w < 3; w++) begin
      clearPhase();
      setCtrl(1'b1, modes[w], 3'd7, 8'd255, 1'b0);
      i_data  = 32'h4000_4000;
      i_valid = 1'b1;
      step();
      step();
      i_valid = 1'b0;
      checks++;
      if (o_valid !== 1'b1 || o_data !== {exp0[w], exp0[w]})
        $display("[TB] FAIL wave mode%0d s0: o_data=%h, want %h%h", modes[w], o_data, exp0[w], exp0[w]);
      else passes++;
      step();
      checks++;
      if (o_valid !== 1'b1 || o_data !== {exp1[w], exp1[w]})
        $display("[TB] FAIL wave mode%0d s1: o_data=%h, want %h%h", modes[w], o_data, exp1[w], exp1[w]);
      else passes++;
    end
  endtask

  task automatic test_enable_toggle();
    clearPhase();
    setCtrl(1'b1, 2'd2, 3'd7, 8'd255, 1'b0);
    i_data  = 32'h4000_4000;
    i_valid = 1'b1;
    repeat (3) step();
    i_valid  = 1'b0;
    i_enable = 1'b0;
    step();
    i_enable = 1'b1;
    i_valid  = 1'b1;
    step();
    i_valid = 1'b0;
    step();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 32'h0040_0040)
      $display("[TB] FAIL enable_restart: o_data=%h, want 00400040", o_data);
    else passes++;
  endtask

  task automatic test_neg_full();
    for (int e = 0; e < 2; e++) begin
      setCtrl(1'(e), 2'd0, 3'd3, 8'd0, 1'b0);
      i_data  = 32'h8000_8000;
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      step();
      checks++;
      if (o_valid !== 1'b1 || o_data !== 32'h8000_8000)
        $display("[TB] FAIL neg_full en%0d: o_data=%h, want 80008000", e, o_data);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 6;
    logic [31:0] tbl [N];
    int pulses;
    tbl[0] = 32'h0001_0002; tbl[1] = 32'h7FFF_8000; tbl[2] = 32'hFFFF_0000;
    tbl[3] = 32'h1234_5678; tbl[4] = 32'hC000_4000; tbl[5] = 32'h00FF_FF00;
    setCtrl(1'b0, 2'd0, 3'd0, 8'd0, 1'b0);
    pulses = 0;
    for (int n = 0; n < N + 4; n++) begin
      i_valid = (n < N);
      i_data  = (n < N) ? tbl[n] : 32'h0;
      step();
      if (o_valid === 1'b1) pulses++;
      if (n >= 1 && n <= N) begin
        checks++;
        if (o_valid !== 1'b1 || o_data !== tbl[n-1])
          $display("[TB] FAIL b2b sample%0d: o_valid=%b o_data=%h, want 1/%h", n - 1, o_valid, o_data, tbl[n-1]);
        else passes++;
      end
    end
    checks++;
    if (pulses != N)
      $display("[TB] FAIL b2b_count: pulses=%0d, want %0d", pulses, N);
    else passes++;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data  = 32'h0;
    setCtrl(1'b0, 2'd0, 3'd0, 8'd0, 1'b0);
    test_reset();
    test_reset_mid();
    test_bypass();
    test_depth_zero();
    test_neg_full();
    test_back_to_back();
    test_square_max();
`ifndef TREMOLO_SMOOTH_EN
    test_autopan();
    test_waveforms();
    test_enable_toggle();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
